// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
// The master drives the count controls; the slave (the counter) returns count and flags.
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
) ();
    logic             enable;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             at_limit;

    modport master (
        output enable, up, load, load_value,
        input  count, wrap, at_limit
    );

    modport slave (
        input  enable, up, load, load_value,
        output count, wrap, at_limit
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with parallel load, wrap/saturate limit handling,
// clock-enable prescaler and terminal-count flags.
module updown_mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX      = (32'd1 << WIDTH) - 32'd1,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    updown_mod_counter_if.slave    bus
);
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_V   = {WIDTH{1'b0}};
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PRE_ZERO = {PW{1'b0}};

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;
    logic [PW-1:0]    pre_r;

    logic [WIDTH-1:0] step_count_s;
    logic             step_wrap_s;
    logic [WIDTH-1:0] count_next_s;
    logic             wrap_next_s;
    logic [PW-1:0]    pre_next_s;
    logic             at_max_s;
    logic             at_zero_s;

    assign at_max_s  = (count_r == MAX_V);
    assign at_zero_s = (count_r == ZERO_V);

    // Value the counter would take on a step, with explicit limit compares instead of overflow.
    always_comb begin
        step_count_s = count_r;
        step_wrap_s  = 1'b0;
        if (bus.up) begin
            if (at_max_s) begin
                if (SATURATE != 0) begin
                    step_count_s = MAX_V;
                    step_wrap_s  = 1'b0;
                end else begin
                    step_count_s = ZERO_V;
                    step_wrap_s  = 1'b1;
                end
            end else begin
                step_count_s = count_r + WIDTH'(1);
                step_wrap_s  = 1'b0;
            end
        end else begin
            if (at_zero_s) begin
                if (SATURATE != 0) begin
                    step_count_s = ZERO_V;
                    step_wrap_s  = 1'b0;
                end else begin
                    step_count_s = MAX_V;
                    step_wrap_s  = 1'b1;
                end
            end else begin
                step_count_s = count_r - WIDTH'(1);
                step_wrap_s  = 1'b0;
            end
        end
    end

    // Next-state selection: load beats a step; the prescaler gates when steps happen.
    always_comb begin
        count_next_s = count_r;
        wrap_next_s  = 1'b0;
        pre_next_s   = pre_r;
        if (bus.load) begin
            if (bus.load_value > MAX_V) begin
                count_next_s = MAX_V;
            end else begin
                count_next_s = bus.load_value;
            end
            pre_next_s = PRE_ZERO;
        end else if (bus.enable) begin
            if (pre_r == PRE_LAST) begin
                pre_next_s   = PRE_ZERO;
                count_next_s = step_count_s;
                wrap_next_s  = step_wrap_s;
            end else begin
                pre_next_s   = pre_r + PW'(1);
            end
        end else begin
            pre_next_s   = pre_r;
        end
    end

    // State registers with synchronous reset taking priority over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= ZERO_V;
            wrap_r  <= 1'b0;
            pre_r   <= PRE_ZERO;
        end else begin
            count_r <= count_next_s;
            wrap_r  <= wrap_next_s;
            pre_r   <= pre_next_s;
        end
    end

    assign bus.count    = count_r;
    assign bus.wrap     = wrap_r;
    assign bus.at_limit = (bus.up && at_max_s) || (!bus.up && at_zero_s);
endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: four counter configurations share one stimulus stream and
// are compared every cycle against an arithmetic reference model.
module tb_updown_mod_counter;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_v;
    logic       ld;
    logic [7:0] lv;

    always #5 clk = ~clk;

    int c_max [4] = '{255, 9, 9, 200};
    int c_sat [4] = '{0, 0, 1, 0};
    int c_pre [4] = '{1, 1, 1, 3};

    updown_mod_counter_if #(.WIDTH(8)) ifc0 ();
    updown_mod_counter_if #(.WIDTH(8)) ifc1 ();
    updown_mod_counter_if #(.WIDTH(8)) ifc2 ();
    updown_mod_counter_if #(.WIDTH(8)) ifc3 ();

    assign ifc0.enable = en; assign ifc0.up = up_v; assign ifc0.load = ld; assign ifc0.load_value = lv;
    assign ifc1.enable = en; assign ifc1.up = up_v; assign ifc1.load = ld; assign ifc1.load_value = lv;
    assign ifc2.enable = en; assign ifc2.up = up_v; assign ifc2.load = ld; assign ifc2.load_value = lv;
    assign ifc3.enable = en; assign ifc3.up = up_v; assign ifc3.load = ld; assign ifc3.load_value = lv;

    updown_mod_counter #(.WIDTH(8), .MAX(255), .SATURATE(0), .PRESCALE(1)) dut0 (.clk(clk), .reset(rst), .bus(ifc0.slave));
    updown_mod_counter #(.WIDTH(8), .MAX(9),   .SATURATE(0), .PRESCALE(1)) dut1 (.clk(clk), .reset(rst), .bus(ifc1.slave));
    updown_mod_counter #(.WIDTH(8), .MAX(9),   .SATURATE(1), .PRESCALE(1)) dut2 (.clk(clk), .reset(rst), .bus(ifc2.slave));
    updown_mod_counter #(.WIDTH(8), .MAX(200), .SATURATE(0), .PRESCALE(3)) dut3 (.clk(clk), .reset(rst), .bus(ifc3.slave));

    logic [7:0] dc [4];
    logic       dw [4];
    logic       da [4];
    assign dc[0] = ifc0.count; assign dw[0] = ifc0.wrap; assign da[0] = ifc0.at_limit;
    assign dc[1] = ifc1.count; assign dw[1] = ifc1.wrap; assign da[1] = ifc1.at_limit;
    assign dc[2] = ifc2.count; assign dw[2] = ifc2.wrap; assign da[2] = ifc2.at_limit;
    assign dc[3] = ifc3.count; assign dw[3] = ifc3.wrap; assign da[3] = ifc3.at_limit;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state: count, enabled-edge phase, wrap flag
    int m_c [4];
    int m_p [4];
    bit m_w [4];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, idx, act, exp, $time);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_c[i] = 0; m_p[i] = 0; m_w[i] = 1'b0;
            end else if (ld) begin
                m_c[i] = (int'(lv) > c_max[i]) ? c_max[i] : int'(lv);
                m_p[i] = 0; m_w[i] = 1'b0;
            end else if (en) begin
                m_w[i] = 1'b0;
                if (m_p[i] + 1 < c_pre[i]) begin
                    m_p[i] = m_p[i] + 1;
                end else begin
                    int nxt;
                    m_p[i] = 0;
                    nxt = up_v ? m_c[i] + 1 : m_c[i] - 1;
                    if (nxt > c_max[i] || nxt < 0) begin
                        if (c_sat[i] != 0) begin
                            nxt = m_c[i];
                        end else begin
                            nxt = (nxt + c_max[i] + 1) % (c_max[i] + 1);
                            m_w[i] = 1'b1;
                        end
                    end
                    m_c[i] = nxt;
                end
            end else begin
                m_w[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("model_count", i, dc[i], m_c[i]);
            chk("model_wrap", i, dw[i], m_w[i]);
            chk("model_at_limit", i, da[i],
                ((up_v && m_c[i] == c_max[i]) || (!up_v && m_c[i] == 0)) ? 1 : 0);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic l, input logic [7:0] v);
        rst = r; en = e; up_v = u; ld = l; lv = v;
    endtask

    typedef struct {
        logic       r, e, u, l;
        logic [7:0] v;
        int         c;
        logic       w, al;
    } vec_t;

    vec_t vt [16];
    int   exp_c3 [7] = '{0, 0, 0, 1, 1, 1, 2};
    logic en_pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bit   wrap_seen;

    initial begin
        // directed vectors for the MAX=9 wrapping counter
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  0, 1'b0, 1'b1};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  9, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  8, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  7, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0,  7, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd12, 9, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  0, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd5,  5, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  6, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  5, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd9,  9, 1'b0, 1'b1};
        vt[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,  0, 1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd9,  9, 1'b0, 1'b1};
        vt[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd3,  0, 1'b0, 1'b0};
        vt[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  9, 1'b1, 1'b0};
        vt[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd4,  0, 1'b0, 1'b1};

        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 16; k++) begin
            drive(vt[k].r, vt[k].e, vt[k].u, vt[k].l, vt[k].v);
            tick();
            chk("vec_count", k, dc[1], vt[k].c);
            chk("vec_wrap", k, dw[1], vt[k].w);
            chk("vec_at_limit", k, da[1], vt[k].al);
        end

        // full 8-bit up sweep with a single wrap
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        for (int i = 1; i <= 256; i++) begin
            tick();
            chk("sweep_count", i, dc[0], i % 256);
            chk("sweep_wrap", i, dw[0], (i == 256) ? 1 : 0);
            chk("sweep_at_limit", i, da[0], (i == 255) ? 1 : 0);
        end

        // saturating limits
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        tick();
        wrap_seen = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dw[2] !== 1'b0) wrap_seen = 1'b1;
        end
        chk("sat_high_count", 2, dc[2], 9);
        up_v = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dw[2] !== 1'b0) wrap_seen = 1'b1;
        end
        chk("sat_low_count", 2, dc[2], 0);
        chk("sat_low_at_limit", 2, da[2], 1);
        chk("sat_no_wrap", 2, wrap_seen, 0);

        // prescaler with gaps in enable, then a load mid-phase
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, en_pat[i], 1'b1, 1'b0, 8'd0);
            tick();
            chk("pre_count", i, dc[3], exp_c3[i]);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd50);
        tick();
        chk("pre_load", 3, dc[3], 50);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(); chk("pre_phase1", 3, dc[3], 50);
        tick(); chk("pre_phase2", 3, dc[3], 50);
        tick(); chk("pre_phase3", 3, dc[3], 51);

        // load beats enable, then ordinary steps
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'd100);
        tick(); chk("load_en_count", 0, dc[0], 100);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(); chk("after_load1", 0, dc[0], 101);
        tick(); chk("after_load2", 0, dc[0], 102);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(63) == 0);
            ld  = ($urandom_range(15) == 0);
            lv  = 8'($urandom_range(255));
            en  = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) up_v = ~up_v;
            tick();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
